prbs16_checker: RTL and testbench
=================================

# prbs16_checker

Self-synchronizing serial checker for the 16-bit XNOR PRBS produced by the team's 16-bit LFSR generator. Consumes one received bit per valid cycle, acquires lock by predicting each bit from the previous 16, then counts bit errors while locked. It sits at the receive end of the PRBS link-test path, opposite the generator.

## Interface
- LOCK_COUNT, 32: consecutive correct predictions needed to enter LOCKED (≥1).
- UNLOCK_ERRS, 4: consecutive mispredictions in LOCKED that force return to HUNT (≥1).
- CNT_W, 16: width of err_count and bit_count.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_bit carries a received bit this cycle.
- in_bit  in  1  received PRBS bit.
- clear_cnt  in  1  synchronous clear of err_count/bit_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mispredicted bit while LOCKED.
- err_count  out  CNT_W  saturating error count.
- bit_count  out  CNT_W  saturating count of bits checked while LOCKED (see Configuration).

## Operation
- Sequence: r[15:0] history, newest bit at r[0]; predicted bit p = ~(r[15]^r[14]^r[12]^r[3]). Each accepted bit shifts in as {r[14:0], bit}.
- States: HUNT, LOCKED. Only in_valid=1 cycles advance anything.
- HUNT: shift in received in_bit. Fill counter counts 0..16; no comparison until 16 bits held. After fill, compare in_bit with p: match increments match_cnt, mismatch clears it. A match with r==16'hFFFF (XNOR lock-up state) does not count and clears match_cnt. When match_cnt reaches LOCK_COUNT → LOCKED, clear miss_cnt.
- LOCKED: compare in_bit with p. Shift in p (flywheel), not in_bit, so isolated errors do not corrupt the prediction. Mismatch: err_pulse, err_count+1 (saturate at all-ones), miss_cnt+1; match clears miss_cnt. When miss_cnt reaches UNLOCK_ERRS → HUNT with fill counter and match_cnt cleared (full 16-bit refill).
- Errors in HUNT are never counted and never pulse err_pulse.
- clear_cnt and an error in the same cycle: clear applied first, then increment → err_count = 1. clear_cnt with no error → 0.
- reset at any time (including mid-lock) returns to HUNT with all counters cleared; no partial state retained.

## Timing
- All outputs registered. Reset values: locked 0, err_pulse 0, err_count 0, bit_count 0; internal r 0, fill 0, match_cnt 0, miss_cnt 0, state HUNT.
- err_pulse high in the cycle after the offending in_valid cycle, for exactly one cycle.
- locked rises in the cycle after the in_valid cycle carrying the LOCK_COUNT-th match; falls in the cycle after the UNLOCK_ERRS-th consecutive miss (that miss still pulses err_pulse and counts).
- Minimum acquisition from reset with clean stream: 16 + LOCK_COUNT valid bits.
- in_valid gaps of any length are transparent: state holds, err_pulse 0.

## Configuration
- PRBS_CHK_BITCNT_EN defined: bit_count increments (saturating) on every in_valid cycle while LOCKED, including errored bits; cleared by clear_cnt/reset; clear-and-increment same cycle → 1.
- Not defined: bit_count port still present, driven constant 0; no counter logic.

## Test plan
- Reset, then generator model seeded 16'hACE1 streamed continuously, default parameters → locked rises cycle after 48th valid bit; err_count stays 0 for 1000 bits; bit_count (macro on) = number of bits after lock.
- After lock, invert only bit index 200 → single err_pulse, err_count=1, locked stays 1, no further errors (flywheel).
- After lock, invert 4 consecutive bits → err_count=4, locked drops after 4th; clean stream resumes → relock after 16+32 further valid bits, err_count holds 4.
- 300 consecutive 1 bits from reset → locked never asserts, err_count 0.
- Clean stream with in_valid toggling pseudo-randomly (≈50%) → lock after exactly 48 valid bits, zero errors; reset mid-lock → locked 0 next cycle, counts 0.
- clear_cnt asserted in same valid cycle as an injected error with err_count=5 → err_count=1 next cycle; force 2^CNT_W+3 errors (CNT_W=4 build) → err_count saturates at 15.

Source files
------------

// File: rtl/prbs16_checker_if.sv
// Receive-side bundle for the PRBS16 checker: received bit stream in, lock/error status out.
interface prbs16_checker_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_bit;
  logic             clear_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output in_valid, in_bit, clear_cnt,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  in_valid, in_bit, clear_cnt,
    output locked, err_pulse, err_count, bit_count
  );
endinterface

// File: rtl/prbs16_checker.sv
// Self-synchronizing checker for the 16-bit XNOR PRBS (taps 16,15,13,4).
// Define PRBS_CHK_BITCNT_EN to enable the checked-bit counter on bit_count.
module prbs16_checker #(
  parameter int LOCK_COUNT  = 32,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input logic             clk,
  input logic             reset,
  prbs16_checker_if.slave bus
);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_ERRS + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_ERRS - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [15:0]        hist, hist_nxt;
  logic [4:0]         fill, fill_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_nxt;
  logic               err_pulse_q, err_pulse_nxt;
  logic [CNT_W-1:0]   err_count_q, err_count_nxt, err_base;
  logic               predicted;
  logic               mismatch;

  assign predicted = ~(hist[15] ^ hist[14] ^ hist[12] ^ hist[3]);
  assign mismatch  = (bus.in_bit != predicted);
  // Clear takes effect before any same-cycle increment.
  assign err_base  = bus.clear_cnt ? '0 : err_count_q;

  always_comb begin
    state_nxt     = state;
    hist_nxt      = hist;
    fill_nxt      = fill;
    match_nxt     = match_cnt;
    miss_nxt      = miss_cnt;
    err_pulse_nxt = 1'b0;
    err_count_nxt = err_base;
    case (state)
      HUNT: begin
        if (bus.in_valid) begin
          hist_nxt = {hist[14:0], bus.in_bit};
          if (fill != 5'd16) begin
            fill_nxt = fill + 5'd1;
          // All-ones history is the XNOR lock-up state and predicts itself forever.
          end else if (!mismatch && hist != 16'hFFFF) begin
            if (match_cnt == MATCH_LAST) begin
              state_nxt = LOCKED;
              match_nxt = '0;
              miss_nxt  = '0;
            end else begin
              match_nxt = match_cnt + MATCH_W'(1);
            end
          end else begin
            match_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (bus.in_valid) begin
          // Flywheel: feed back the prediction so a lone bit error cannot poison history.
          hist_nxt = {hist[14:0], predicted};
          if (mismatch) begin
            err_pulse_nxt = 1'b1;
            err_count_nxt = (&err_base) ? err_base : err_base + CNT_W'(1);
            if (miss_cnt == MISS_LAST) begin
              state_nxt = HUNT;
              fill_nxt  = '0;
              match_nxt = '0;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss_cnt + MISS_W'(1);
            end
          end else begin
            miss_nxt = '0;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      hist        <= '0;
      fill        <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state       <= state_nxt;
      hist        <= hist_nxt;
      fill        <= fill_nxt;
      match_cnt   <= match_nxt;
      miss_cnt    <= miss_nxt;
      err_pulse_q <= err_pulse_nxt;
      err_count_q <= err_count_nxt;
    end
  end

  assign bus.locked    = (state == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

`ifdef PRBS_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_count_q, bit_count_nxt, bit_base;

  assign bit_base = bus.clear_cnt ? '0 : bit_count_q;

  always_comb begin
    bit_count_nxt = bit_base;
    if (state == LOCKED && bus.in_valid && !(&bit_base)) begin
      bit_count_nxt = bit_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_nxt;
    end
  end

  assign bus.bit_count = bit_count_q;
`else
  assign bus.bit_count = '0;
`endif
endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker: acquisition, flywheel, unlock/relock, lock-up, gaps, clear and saturation.
module tb_prbs16_checker;
  logic        clk;
  logic        reset;
  logic [15:0] gen_state;
  int          checks;
  int          errors;

  prbs16_checker_if #(.CNT_W(16)) bus ();
  prbs16_checker_if #(.CNT_W(4))  bus4 ();

  // The narrow-counter instance sees exactly the same stream as the default one.
  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_bit    = bus.in_bit;
  assign bus4.clear_cnt = bus.clear_cnt;

  prbs16_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  prbs16_checker #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_bit(output logic b);
    b = ~(gen_state[15] ^ gen_state[14] ^ gen_state[12] ^ gen_state[3]);
    gen_state = {gen_state[14:0], b};
  endtask

  // One clock of stimulus; outputs are sampled 1 ns after the edge on return.
  task automatic send(input logic v, input logic b, input logic c);
    bus.in_valid  = v;
    bus.in_bit    = b;
    bus.clear_cnt = c;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.clear_cnt = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.clear_cnt = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    gen_state = 16'hACE1;
  endtask

  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      send(1'b1, b, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    bus.clear_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %0b expected 0", bus.locked); end
    checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_pulse: got %0b expected 0", bus.err_pulse); end
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_err_count: got %0d expected 0", bus.err_count); end
    checks++; if (bus.bit_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_bit_count: got %0d expected 0", bus.bit_count); end
    reset = 1'b0;
  endtask

  task automatic test_acquire();
    logic b;
    logic saw_err;
    logic lost;
    int   exp_bits;
    do_reset();
    for (int i = 1; i <= 48; i++) begin
      next_bit(b);
      send(1'b1, b, 1'b0);
      if (i == 47) begin
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL acquire_early: locked=%0b after 47 bits, expected 0", bus.locked); end
      end
      if (i == 48) begin
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL acquire_lock48: locked=%0b after 48 bits, expected 1", bus.locked); end
      end
    end
    saw_err = 1'b0;
    lost    = 1'b0;
    for (int i = 49; i <= 1000; i++) begin
      next_bit(b);
      send(1'b1, b, 1'b0);
      if (bus.err_pulse) saw_err = 1'b1;
      if (!bus.locked) lost = 1'b1;
    end
    checks++; if (saw_err !== 1'b0) begin errors++; $display("[TB] FAIL acquire_no_pulse: saw err_pulse=%0b expected 0", saw_err); end
    checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL acquire_hold: lost lock=%0b expected 0", lost); end
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("[TB] FAIL acquire_err_count: got %0d expected 0", bus.err_count); end
`ifdef PRBS_CHK_BITCNT_EN
    exp_bits = 952;
`else
    exp_bits = 0;
`endif
    checks++; if (bus.bit_count !== 16'(exp_bits)) begin errors++; $display("[TB] FAIL acquire_bit_count: got %0d expected %0d", bus.bit_count, exp_bits); end
  endtask

  task automatic test_single_error();
    logic b;
    int   extra;
    do_reset();
    extra = 0;
    for (int idx = 0; idx < 400; idx++) begin
      next_bit(b);
      if (idx == 200) b = ~b;
      send(1'b1, b, 1'b0);
      if (idx == 200) begin
        checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("[TB] FAIL single_pulse: got %0b expected 1", bus.err_pulse); end
        checks++; if (bus.err_count !== 16'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", bus.err_count); end
      end
      if (idx == 201) begin
        checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse_width: got %0b expected 0", bus.err_pulse); end
      end
      if (idx > 201 && bus.err_pulse) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL flywheel_extra: got %0d pulses expected 0", extra); end
    checks++; if (bus.err_count !== 16'd1) begin errors++; $display("[TB] FAIL flywheel_count: got %0d expected 1", bus.err_count); end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL flywheel_locked: got %0b expected 1", bus.locked); end
  endtask

  task automatic test_burst_unlock();
    logic b;
    int   extra;
    do_reset();
    send_clean(100);
    for (int k = 0; k < 4; k++) begin
      next_bit(b);
      send(1'b1, ~b, 1'b0);
      checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("[TB] FAIL burst_pulse%0d: got %0b expected 1", k, bus.err_pulse); end
      checks++; if (bus.locked !== (k < 3)) begin errors++; $display("[TB] FAIL burst_locked%0d: got %0b expected %0b", k, bus.locked, (k < 3)); end
    end
    checks++; if (bus.err_count !== 16'd4) begin errors++; $display("[TB] FAIL burst_count: got %0d expected 4", bus.err_count); end
    extra = 0;
    for (int i = 1; i <= 48; i++) begin
      next_bit(b);
      send(1'b1, b, 1'b0);
      if (bus.err_pulse) extra++;
      if (i == 47) begin
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL relock_early: got %0b expected 0", bus.locked); end
      end
      if (i == 48) begin
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL relock48: got %0b expected 1", bus.locked); end
      end
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL relock_hunt_pulses: got %0d expected 0", extra); end
    checks++; if (bus.err_count !== 16'd4) begin errors++; $display("[TB] FAIL relock_count_hold: got %0d expected 4", bus.err_count); end
  endtask

  task automatic test_all_ones();
    logic seen;
    do_reset();
    seen = 1'b0;
    repeat (300) begin
      send(1'b1, 1'b1, 1'b0);
      if (bus.locked || bus.err_pulse) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL ones_lockup: locked/pulse seen=%0b expected 0", seen); end
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("[TB] FAIL ones_count: got %0d expected 0", bus.err_count); end
  endtask

  task automatic test_gapped_valid();
    logic b;
    logic early;
    int   nvalid;
    int   cycles;
    do_reset();
    nvalid = 0;
    cycles = 0;
    early  = 1'b0;
    while (nvalid < 48 && cycles < 2000) begin
      cycles++;
      if ($urandom_range(0, 1) == 1) begin
        next_bit(b);
        send(1'b1, b, 1'b0);
        nvalid++;
        if (nvalid < 48 && bus.locked) early = 1'b1;
      end else begin
        send(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        if (bus.err_pulse) early = 1'b1;
      end
    end
    checks++; if (nvalid !== 48) begin errors++; $display("[TB] FAIL gap_budget: got %0d valid bits expected 48", nvalid); end
    checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL gap_early: got %0b expected 0", early); end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL gap_lock48: got %0b expected 1", bus.locked); end
    repeat (5) send(1'b0, 1'b1, 1'b0);
    checks++; if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL gap_hold: locked=%0b pulse=%0b expected 1/0", bus.locked, bus.err_pulse); end
    next_bit(b);
    send(1'b1, ~b, 1'b0);
    checks++; if (bus.err_count !== 16'd1) begin errors++; $display("[TB] FAIL gap_err: got %0d expected 1", bus.err_count); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL midlock_reset_locked: got %0b expected 0", bus.locked); end
    checks++; if (bus.err_count !== 16'd0 || bus.bit_count !== 16'd0) begin errors++; $display("[TB] FAIL midlock_reset_counts: err=%0d bits=%0d expected 0/0", bus.err_count, bus.bit_count); end
    reset = 1'b0;
  endtask

  task automatic test_clear_saturate();
    logic b;
    do_reset();
    send_clean(48);
    repeat (5) begin
      next_bit(b);
      send(1'b1, ~b, 1'b0);
      next_bit(b);
      send(1'b1, b, 1'b0);
    end
    checks++; if (bus.err_count !== 16'd5 || bus4.err_count !== 4'd5) begin errors++; $display("[TB] FAIL pre_clear: got %0d/%0d expected 5/5", bus.err_count, bus4.err_count); end
    next_bit(b);
    send(1'b1, ~b, 1'b1);
    checks++; if (bus.err_count !== 16'd1 || bus4.err_count !== 4'd1) begin errors++; $display("[TB] FAIL clear_with_err: got %0d/%0d expected 1/1", bus.err_count, bus4.err_count); end
`ifdef PRBS_CHK_BITCNT_EN
    checks++; if (bus.bit_count !== 16'd1) begin errors++; $display("[TB] FAIL clear_bitcnt_inc: got %0d expected 1", bus.bit_count); end
`endif
    next_bit(b);
    send(1'b1, b, 1'b0);
    send(1'b0, 1'b0, 1'b1);
    checks++; if (bus.err_count !== 16'd0 || bus4.err_count !== 4'd0) begin errors++; $display("[TB] FAIL clear_only: got %0d/%0d expected 0/0", bus.err_count, bus4.err_count); end
`ifdef PRBS_CHK_BITCNT_EN
    checks++; if (bus.bit_count !== 16'd0) begin errors++; $display("[TB] FAIL clear_bitcnt: got %0d expected 0", bus.bit_count); end
`endif
    repeat (19) begin
      next_bit(b);
      send(1'b1, ~b, 1'b0);
      next_bit(b);
      send(1'b1, b, 1'b0);
    end
    checks++; if (bus4.err_count !== 4'd15) begin errors++; $display("[TB] FAIL saturate_w4: got %0d expected 15", bus4.err_count); end
    checks++; if (bus.err_count !== 16'd19) begin errors++; $display("[TB] FAIL count_w16: got %0d expected 19", bus.err_count); end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL saturate_locked: got %0b expected 1", bus.locked); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    gen_state = 16'hACE1;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.clear_cnt = 1'b0;
    $display("[TB] starting prbs16_checker bench");
    test_reset();
    test_acquire();
    test_single_error();
    test_burst_unlock();
    test_all_ones();
    test_gapped_valid();
    test_clear_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
